// File: rtl/ctrl_pipe_tracker_pkg.sv
// Shared definitions for the control-bundle pipeline tracker: default bundle
// geometry, bundle bit positions and the per-stage load selection type.
package ctrl_pipe_tracker_pkg;

  localparam int CTRL_W_DEF   = 24;
  localparam int STAGES_DEF   = 3;
  localparam int HALT_BIT_DEF = 3;
  localparam int ERR_BIT_DEF  = 0;
  localparam int CNT_W_DEF    = 16;

  // What a pipeline register does on the next clock edge
  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_BUBBLE = 2'd1,
    SEL_HOLD   = 2'd2
  } stage_sel_e;

endpackage

// File: rtl/ctrl_pipe_tracker_stage_reg.sv
// One pipeline register holding a control bundle plus its valid flag.
// A bubble always carries an all-zero bundle so that downstream write enables
// are gated without looking at the valid bit.
module ctrl_pipe_tracker_stage_reg
  import ctrl_pipe_tracker_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  stage_sel_e        sel,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              q_valid
);

  // Load, insert a bubble, or hold the current bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl  <= '0;
      q_valid <= 1'b0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          q_ctrl  <= d_ctrl;
          q_valid <= d_valid;
        end
        SEL_BUBBLE: begin
          q_ctrl  <= '0;
          q_valid <= 1'b0;
        end
        default: begin
          q_ctrl  <= q_ctrl;
          q_valid <= q_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe_tracker.sv
// Carries the decoded control bundle through STAGES pipeline registers with
// stall bubbles, branch flush of the youngest stages, sticky halt/err capture
// at retirement and saturating retired/bubble counters.
module ctrl_pipe_tracker
  import ctrl_pipe_tracker_pkg::*;
#(
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int STAGES      = STAGES_DEF,
  parameter int FLUSH_DEPTH = 2,
  parameter int HALT_BIT    = HALT_BIT_DEF,
  parameter int ERR_BIT     = ERR_BIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        ctrl_id,
  input  logic                     valid_id,
  input  logic                     stall,
  input  logic                     flush,
  output logic [STAGES*CTRL_W-1:0] ctrl_stages,
  output logic [STAGES-1:0]        valid_stages,
  output logic [CTRL_W-1:0]        ctrl_wb,
  output logic                     valid_wb,
  output logic                     halted,
  output logic                     err,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0][CTRL_W-1:0] q_ctrl;
  logic [STAGES-1:0][CTRL_W-1:0] d_ctrl;
  logic [STAGES-1:0]             q_valid;
  logic [STAGES-1:0]             d_valid;
  stage_sel_e                    sel [STAGES];
  logic                          bubble_ins;
  logic                          retire;

  // Per-stage action: halt freezes everything, flush beats stall
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sel[k] = SEL_LOAD;
      if (halted) begin
        sel[k] = SEL_HOLD;
      end else if (flush && (k < FLUSH_DEPTH)) begin
        sel[k] = SEL_BUBBLE;
      end else if (stall && (k == 0)) begin
        sel[k] = SEL_BUBBLE;
      end
    end
  end

  // Next bundle for each stage; an invalid ID word enters as an all-zero bundle
  always_comb begin
    d_ctrl     = '0;
    d_valid    = '0;
    d_ctrl[0]  = valid_id ? ctrl_id : '0;
    d_valid[0] = valid_id;
    for (int k = 1; k < STAGES; k++) begin
      d_ctrl[k]  = q_ctrl[k-1];
      d_valid[k] = q_valid[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ctrl_pipe_tracker_stage_reg #(
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel[g]),
      .d_ctrl  (d_ctrl[g]),
      .d_valid (d_valid[g]),
      .q_ctrl  (q_ctrl[g]),
      .q_valid (q_valid[g])
    );
  end

  assign ctrl_stages  = q_ctrl;
  assign valid_stages = q_valid;
  assign ctrl_wb      = q_ctrl[STAGES-1];
  assign valid_wb     = q_valid[STAGES-1];

  assign bubble_ins = !halted && (stall || flush);
  assign retire     = !halted && valid_wb;

  // Retirement bookkeeping: sticky halt/err and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted      <= 1'b0;
      err         <= 1'b0;
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (retire) begin
        if (retired_cnt != CNT_MAX) begin
          retired_cnt <= retired_cnt + CNT_ONE;
        end
        if (ctrl_wb[HALT_BIT]) begin
          halted <= 1'b1;
        end
        if (ctrl_wb[ERR_BIT]) begin
          err <= 1'b1;
        end
      end
      if (bubble_ins && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

endmodule
